// File: rtl/huffman_stream_encoder.sv
`default_nettype none
// ==== huffman_stream_encoder : FIFO-buffered, table-driven Huffman encoder, MSB-first serial output ====
// Revision 1.0
module huffman_stream_encoder #(
   parameter int  SYM_W      = 4,
   parameter int  MAX_LEN    = 8,
   parameter int  FIFO_DEPTH = 8,
   localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SYM_W-1:0]   data_in,
   input  logic               wr_en,
   output logic               full,
   input  logic               tbl_we,
   input  logic [SYM_W-1:0]   tbl_addr,
   input  logic [MAX_LEN-1:0] tbl_code,
   input  logic [LEN_W-1:0]   tbl_len,
   output logic               out_bit,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               last,
   output logic               busy,
   output logic               overflow,
   output logic               err
);

   localparam int NSYM  = 1 << SYM_W;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   logic [MAX_LEN-1:0] r_code_tbl [NSYM];
   logic [LEN_W-1:0]   r_len_tbl  [NSYM];
   logic [SYM_W-1:0]   r_fifo     [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [MAX_LEN-1:0] r_shreg;
   logic [LEN_W-1:0]   r_cnt;
   logic               r_out_valid;
   logic               r_out_bit;
   logic               r_last;
   logic               r_overflow;
   logic               r_err;

   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_accept;
   logic               w_final;
   logic               w_tbl_bad;
   logic               w_zero_len;
   logic [SYM_W-1:0]   w_sym;
   logic [MAX_LEN-1:0] w_code;
   logic [LEN_W-1:0]   w_len;
   logic [MAX_LEN-1:0] w_load;
   logic [MAX_LEN-1:0] w_next;

   assign w_empty    = (r_count == '0);
   assign full       = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push     = wr_en & ~full;
   assign w_accept   = (r_state == SHIFT) & out_ready;
   assign w_final    = w_accept & (r_cnt == LEN_W'(1));
   // Pop from IDLE, or on the last accepted bit so the next codeword follows with no bubble
   assign w_pop      = ~w_empty & ((r_state == IDLE) | w_final);
   assign w_sym      = r_fifo[r_rd_ptr];
   assign w_code     = r_code_tbl[w_sym];
   assign w_len      = r_len_tbl[w_sym];
   assign w_zero_len = (w_len == '0);
   // Left-align the codeword so the bit on the wire is always the shift register MSB
   assign w_load     = w_code << (LEN_W'(MAX_LEN) - w_len);
   assign w_next     = r_shreg << 1;
   assign w_tbl_bad  = tbl_we & (tbl_len > LEN_W'(MAX_LEN));

   assign out_bit    = r_out_bit;
   assign out_valid  = r_out_valid;
   assign last       = r_last;
   assign busy       = (r_state != IDLE) | ~w_empty;
   assign overflow   = r_overflow;
   assign err        = r_err;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (wr_en && full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Reset loads a fixed-length identity code; a pop reads the entry as it was before this edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NSYM; s++) begin
            r_code_tbl[s] <= MAX_LEN'(s);
            r_len_tbl[s]  <= LEN_W'(SYM_W);
         end
      end else if (tbl_we && !w_tbl_bad) begin
         r_code_tbl[tbl_addr] <= tbl_code;
         r_len_tbl[tbl_addr]  <= tbl_len;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_last      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_tbl_bad | (w_pop & w_zero_len);
         if (w_pop && !w_zero_len) begin
            r_state     <= SHIFT;
            r_shreg     <= w_load;
            r_cnt       <= w_len;
            r_out_valid <= 1'b1;
            r_out_bit   <= w_load[MAX_LEN-1];
            r_last      <= (w_len == LEN_W'(1));
         end else if (w_final || w_pop) begin
            // Codeword finished with nothing to load, or a zero-length symbol was dropped
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_last      <= 1'b0;
         end else if (w_accept) begin
            r_shreg   <= w_next;
            r_cnt     <= r_cnt - LEN_W'(1);
            r_out_bit <= w_next[MAX_LEN-1];
            r_last    <= (r_cnt == LEN_W'(2));
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_encoder.sv
`default_nettype none
// tb_huffman_stream_encoder: directed and randomized scenarios checked against a code-table/bit-stream model
module tb_huffman_stream_encoder;

   localparam int SYM_W      = 4;
   localparam int MAX_LEN    = 8;
   localparam int FIFO_DEPTH = 8;
   localparam int LEN_W      = $clog2(MAX_LEN + 1);
   localparam int NSYM       = 1 << SYM_W;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [SYM_W-1:0]   data_in = '0;
   logic               wr_en = 1'b0;
   logic               full;
   logic               tbl_we = 1'b0;
   logic [SYM_W-1:0]   tbl_addr = '0;
   logic [MAX_LEN-1:0] tbl_code = '0;
   logic [LEN_W-1:0]   tbl_len = '0;
   logic               out_bit;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic               last;
   logic               busy;
   logic               overflow;
   logic               err;

   int checks = 0;
   int errors = 0;
   int cyc_count = 0;

   logic [MAX_LEN-1:0] m_code [NSYM];
   int                 m_len  [NSYM];

   logic [255:0] got_bits, got_last, exp_bits, exp_last;
   int           got_n, exp_n, first_t, last_t;

   huffman_stream_encoder #(
      .SYM_W      (SYM_W),
      .MAX_LEN    (MAX_LEN),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .wr_en     (wr_en),
      .full      (full),
      .tbl_we    (tbl_we),
      .tbl_addr  (tbl_addr),
      .tbl_code  (tbl_code),
      .tbl_len   (tbl_len),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .last      (last),
      .busy      (busy),
      .overflow  (overflow),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_count++;

   // Transfers are recorded half a cycle before the edge that accepts them
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         got_bits = {got_bits[254:0], out_bit};
         got_last = {got_last[254:0], last};
         got_n++;
         if (got_n == 1) first_t = cyc_count;
         last_t = cyc_count;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSYM; s++) begin
         m_code[s] = MAX_LEN'(s);
         m_len[s]  = SYM_W;
      end
   endtask

   task automatic clear_stream();
      got_bits = '0; got_last = '0; got_n = 0;
      exp_bits = '0; exp_last = '0; exp_n = 0;
      first_t = 0; last_t = 0;
   endtask

   task automatic add_sym(input int s);
      logic [MAX_LEN-1:0] c;
      c = m_code[s];
      for (int i = m_len[s] - 1; i >= 0; i--) begin
         exp_bits = {exp_bits[254:0], c[i]};
         exp_last = {exp_last[254:0], (i == 0)};
         exp_n++;
      end
   endtask

   task automatic push(input int s);
      data_in = SYM_W'(s);
      wr_en   = 1'b1;
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic tbl_write(input int a, input int c, input int l);
      tbl_addr = SYM_W'(a);
      tbl_code = MAX_LEN'(c);
      tbl_len  = LEN_W'(l);
      tbl_we   = 1'b1;
      cyc();
      tbl_we   = 1'b0;
      if (l <= MAX_LEN) begin
         m_code[a] = MAX_LEN'(c);
         m_len[a]  = l;
      end
   endtask

   task automatic drain(input int budget, input string name);
      int k;
      k = 0;
      out_ready = 1'b1;
      while (busy !== 1'b0 && k < budget) begin
         cyc();
         k++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s drain_timeout busy=%b required 0", name, busy);
      end
   endtask

   task automatic test_reset();
      cyc();
      reset = 1'b1;
      #2;
      checks++;
      if ({out_valid, out_bit, last, busy, full, overflow, err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got valid,bit,last,busy,full,ovf,err=%b required 0000000",
                  {out_valid, out_bit, last, busy, full, overflow, err});
      end
      cyc();
      cyc();
      reset = 1'b0;
      model_reset();
      cyc();
   endtask

   task automatic test_identity();
      out_ready = 1'b1;
      clear_stream();
      add_sym(4'hA);
      push(4'hA);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early valid=%b required 0", out_valid);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
         errors++;
         $display("FAIL latency_first valid=%b bit=%b required 1 1", out_valid, out_bit);
      end
      drain(50, "identity");
      checks++;
      if (got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
         errors++;
         $display("FAIL identity_stream got n=%0d bits=%h last=%h required n=%0d bits=%h last=%h",
                  got_n, got_bits[63:0], got_last[63:0], exp_n, exp_bits[63:0], exp_last[63:0]);
      end
      checks++;
      if (last_t - first_t !== 3) begin
         errors++;
         $display("FAIL identity_consecutive span=%0d required 3", last_t - first_t);
      end
   endtask

   task automatic test_back_to_back();
      tbl_write(3, 3'b110, 3);
      tbl_write(5, 2'b01, 2);
      clear_stream();
      add_sym(3);
      add_sym(5);
      out_ready = 1'b1;
      push(3);
      push(5);
      drain(50, "b2b");
      checks++;
      if (got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
         errors++;
         $display("FAIL b2b_stream got n=%0d bits=%h last=%h required n=%0d bits=%h last=%h",
                  got_n, got_bits[63:0], got_last[63:0], exp_n, exp_bits[63:0], exp_last[63:0]);
      end
      checks++;
      if (last_t - first_t !== 4) begin
         errors++;
         $display("FAIL b2b_no_bubble span=%0d required 4", last_t - first_t);
      end
   endtask

   task automatic test_full_overflow();
      int s;
      out_ready = 1'b0;
      clear_stream();
      // The first symbol moves straight into the stalled shifter, so the FIFO then fills with 8 more
      s = $urandom_range(0, NSYM - 1);
      add_sym(s);
      push(s);
      cyc();
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         s = $urandom_range(0, NSYM - 1);
         add_sym(s);
         push(s);
         if (i == FIFO_DEPTH - 2) begin
            checks++;
            if (full !== 1'b0) begin
               errors++;
               $display("FAIL full_early full=%b required 0", full);
            end
         end
      end
      checks++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_set full=%b ovf=%b required 1 0", full, overflow);
      end
      push($urandom_range(0, NSYM - 1));
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set ovf=%b required 1", overflow);
      end
      drain(400, "full");
      checks++;
      if (got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
         errors++;
         $display("FAIL full_stream got n=%0d bits=%h last=%h required n=%0d bits=%h last=%h",
                  got_n, got_bits[127:0], got_last[127:0], exp_n, exp_bits[127:0], exp_last[127:0]);
      end
      checks++;
      if ($countones(got_last) !== FIFO_DEPTH + 1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL full_codewords got=%0d ovf=%b required %0d 1", $countones(got_last), overflow,
                  FIFO_DEPTH + 1);
      end
   endtask

   task automatic test_stall();
      int  s, k;
      logic pv, pb, pr;
      s = 0;
      for (int t = 0; t < 100; t++) begin
         s = $urandom_range(0, NSYM - 1);
         if (m_len[s] == 4) break;
      end
      clear_stream();
      add_sym(s);
      out_ready = 1'b0;
      push(s);
      k = 0;
      while (busy === 1'b1 && k < 40) begin
         out_ready = ~out_ready;
         pv = out_valid; pb = out_bit; pr = out_ready;
         cyc();
         k++;
         if (pv && !pr) begin
            checks++;
            if (out_valid !== 1'b1 || out_bit !== pb) begin
               errors++;
               $display("FAIL stall_hold valid=%b bit=%b required 1 %b", out_valid, out_bit, pb);
            end
         end
      end
      checks++;
      if (busy !== 1'b0 || got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
         errors++;
         $display("FAIL stall_stream busy=%b got n=%0d bits=%h last=%h required n=%0d bits=%h last=%h",
                  busy, got_n, got_bits[63:0], got_last[63:0], exp_n, exp_bits[63:0], exp_last[63:0]);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_err();
      int pulses, valids;
      out_ready = 1'b1;
      tbl_write(7, 8'hFF, 9);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_badlen err=%b required 1", err);
      end
      cyc();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_oneshot err=%b required 0", err);
      end
      clear_stream();
      add_sym(7);
      push(7);
      drain(50, "err_entry");
      checks++;
      if (got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
         errors++;
         $display("FAIL err_entry_kept got n=%0d bits=%h required n=%0d bits=%h",
                  got_n, got_bits[63:0], exp_n, exp_bits[63:0]);
      end
      tbl_write(2, 0, 0);
      clear_stream();
      push(2);
      pulses = 0; valids = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (err === 1'b1) pulses++;
         if (out_valid === 1'b1) valids++;
      end
      checks++;
      if (pulses !== 1 || valids !== 0 || got_n !== 0) begin
         errors++;
         $display("FAIL err_zero_len pulses=%0d valids=%0d bits=%0d required 1 0 0", pulses, valids, got_n);
      end
   endtask

   task automatic test_reset_midcode();
      int k;
      out_ready = 1'b1;
      clear_stream();
      push(4'hF);
      k = 0;
      while (got_n < 2 && k < 20) begin
         cyc();
         k++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (got_n !== 2 || out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL midreset_now bits=%0d valid=%b busy=%b ovf=%b required 2 0 0 0",
                  got_n, out_valid, busy, overflow);
      end
      cyc();
      cyc();
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) cyc();
      checks++;
      if (got_n !== 2) begin
         errors++;
         $display("FAIL midreset_silent bits=%0d required 2", got_n);
      end
      clear_stream();
      add_sym(4'h1);
      push(4'h1);
      drain(50, "post_reset");
      checks++;
      if (got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
         errors++;
         $display("FAIL post_reset_stream got n=%0d bits=%h last=%h required n=%0d bits=%h last=%h",
                  got_n, got_bits[63:0], got_last[63:0], exp_n, exp_bits[63:0], exp_last[63:0]);
      end
   endtask

   task automatic test_random();
      int n, s, gaps;
      for (int r = 0; r < 20; r++) begin
         out_ready = 1'b1;
         for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
            tbl_write($urandom_range(0, NSYM - 1), $urandom_range(0, 255), $urandom_range(0, 9));
         end
         cyc();
         clear_stream();
         n = $urandom_range(1, FIFO_DEPTH);
         for (int i = 0; i < n; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
               out_ready = 1'($urandom_range(0, 1));
               cyc();
            end
            s = $urandom_range(0, NSYM - 1);
            add_sym(s);
            out_ready = 1'($urandom_range(0, 1));
            push(s);
         end
         drain(600, "random");
         checks++;
         if (got_n !== exp_n || got_bits !== exp_bits || got_last !== exp_last) begin
            errors++;
            $display("FAIL random_stream round=%0d got n=%0d bits=%h last=%h required n=%0d bits=%h last=%h",
                     r, got_n, got_bits[63:0], got_last[63:0], exp_n, exp_bits[63:0], exp_last[63:0]);
         end
      end
   endtask

   initial begin
      clear_stream();
      model_reset();
      test_reset();
      test_identity();
      test_back_to_back();
      test_full_overflow();
      test_stall();
      test_err();
      test_reset_midcode();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
